// File: rtl/nbody_host_ctrl.sv
// Bus initiator that drives one complete n-body run on the accelerator:
// configure, preload bodies, start, poll for DONE, drain results, return to idle.
module nbody_host_ctrl #(
    parameter  int BODIES          = 512,
    parameter  int DATA_WIDTH      = 64,
    parameter  int ADDR_WIDTH      = 16,
    parameter  int READ_LATENCY    = 1,
    parameter  int POLL_LIMIT      = 2**20,
    localparam int BODY_ADDR_WIDTH = $clog2(BODIES)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [BODY_ADDR_WIDTH-1:0] n_bodies,
    input  logic [DATA_WIDTH-1:0]      gap,
    output logic                       busy,
    output logic                       done_o,
    output logic                       error,
    output logic                       src_rd_en,
    output logic [BODY_ADDR_WIDTH-1:0] src_rd_body,
    output logic [2:0]                 src_rd_field,
    input  logic [DATA_WIDTH-1:0]      src_rd_data,
    output logic                       res_valid,
    output logic [BODY_ADDR_WIDTH-1:0] res_body,
    output logic [DATA_WIDTH-1:0]      res_x,
    output logic [DATA_WIDTH-1:0]      res_y,
    output logic                       m_chipselect,
    output logic                       m_write,
    output logic                       m_read,
    output logic [ADDR_WIDTH-1:0]      m_addr,
    output logic [DATA_WIDTH-1:0]      m_writedata,
    input  logic [DATA_WIDTH-1:0]      m_readdata
);

    localparam int BW  = BODY_ADDR_WIDTH;
    localparam int OPW = ADDR_WIDTH - BW;
    localparam int PW  = $clog2(POLL_LIMIT + 1);
    localparam int LW  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    localparam logic [OPW-1:0] OP_GO   = OPW'(0);
    localparam logic [OPW-1:0] OP_READ = OPW'(1);
    localparam logic [OPW-1:0] OP_NB   = OPW'(2);
    localparam logic [OPW-1:0] OP_WX   = OPW'(3);
    localparam logic [OPW-1:0] OP_GAP  = OPW'(8);
    localparam logic [OPW-1:0] OP_DONE = OPW'(64);
    localparam logic [OPW-1:0] OP_RX   = OPW'(65);
    localparam logic [OPW-1:0] OP_RY   = OPW'(66);

    typedef enum logic [4:0] {
        S_IDLE, S_CFG_N, S_CFG_GAP, S_LD_RD, S_LD_WR, S_GO,
        S_POLL_RD, S_POLL_WT, S_RD_X, S_WT_X, S_RD_Y, S_WT_Y,
        S_ACK1, S_ACK2, S_ACK3, S_FIN, S_STOP1, S_STOP2
    } state_t;

    state_t                state_q, state_d;
    logic [BW-1:0]         n_q, body_q, body_d;
    logic [2:0]            field_q, field_d;
    logic [PW-1:0]         poll_q, poll_d;
    logic [LW-1:0]         lat_q, lat_d;
    logic [DATA_WIDTH-1:0] gap_q;
    logic                  set_err, cap_x, cap_y;
    logic                  last_body, lat_last, poll_last, launch;

    assign last_body = (body_q == n_q - 1'b1);
    assign lat_last  = (lat_q == LW'(READ_LATENCY - 1));
    assign poll_last = (poll_q == PW'(POLL_LIMIT - 1));
    assign launch    = (state_q == S_IDLE) && start;

    // FIN already counts as not busy so that busy falls together with done_o
    assign busy = (state_q != S_IDLE) && (state_q != S_FIN);
    assign m_chipselect = m_write | m_read;

    // State, counters, latched run parameters and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            n_q       <= '0;
            body_q    <= '0;
            field_q   <= '0;
            poll_q    <= '0;
            lat_q     <= '0;
            gap_q     <= '0;
            error     <= 1'b0;
            res_valid <= 1'b0;
            res_body  <= '0;
            res_x     <= '0;
            res_y     <= '0;
        end else begin
            state_q   <= state_d;
            body_q    <= body_d;
            field_q   <= field_d;
            poll_q    <= poll_d;
            lat_q     <= lat_d;
            res_valid <= cap_y;
            if (launch) begin
                n_q   <= n_bodies;
                gap_q <= gap;
                error <= 1'b0;
            end
            if (set_err) error <= 1'b1;
            if (cap_x) res_x <= m_readdata;
            if (cap_y) begin
                res_y    <= m_readdata;
                res_body <= body_q;
            end
        end
    end

    // Next state, counter updates and bus/source strobes for the current state
    always_comb begin
        state_d      = state_q;
        body_d       = body_q;
        field_d      = field_q;
        poll_d       = poll_q;
        lat_d        = lat_q;
        set_err      = 1'b0;
        cap_x        = 1'b0;
        cap_y        = 1'b0;
        done_o       = 1'b0;
        src_rd_en    = 1'b0;
        src_rd_body  = '0;
        src_rd_field = '0;
        m_write      = 1'b0;
        m_read       = 1'b0;
        m_addr       = '0;
        m_writedata  = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CFG_N;
                    body_d  = '0;
                    field_d = '0;
                    poll_d  = '0;
                    lat_d   = '0;
                end
            end
            S_CFG_N: begin
                m_write     = 1'b1;
                m_addr      = {OP_NB, BW'(0)};
                m_writedata = DATA_WIDTH'(n_q);
                state_d     = S_CFG_GAP;
            end
            S_CFG_GAP: begin
                m_write     = 1'b1;
                m_addr      = {OP_GAP, BW'(0)};
                m_writedata = gap_q;
                state_d     = (n_q == '0) ? S_GO : S_LD_RD;
            end
            S_LD_RD: begin
                src_rd_en    = 1'b1;
                src_rd_body  = body_q;
                src_rd_field = field_q;
                state_d      = S_LD_WR;
            end
            S_LD_WR: begin
                m_write     = 1'b1;
                m_addr      = {OP_WX + OPW'(field_q), body_q};
                m_writedata = src_rd_data;
                state_d     = S_LD_RD;
                if (field_q == 3'd4) begin
                    field_d = '0;
                    if (last_body) state_d = S_GO;
                    else body_d = body_q + 1'b1;
                end else begin
                    field_d = field_q + 1'b1;
                end
            end
            S_GO: begin
                m_write     = 1'b1;
                m_addr      = {OP_GO, BW'(0)};
                m_writedata = DATA_WIDTH'(1);
                poll_d      = '0;
                state_d     = S_POLL_RD;
            end
            S_POLL_RD: begin
                m_read  = 1'b1;
                m_addr  = {OP_DONE, BW'(0)};
                lat_d   = '0;
                state_d = S_POLL_WT;
            end
            S_POLL_WT: begin
                if (!lat_last) begin
                    lat_d = lat_q + 1'b1;
                end else if (m_readdata[0]) begin
                    body_d  = '0;
                    state_d = (n_q == '0) ? S_ACK1 : S_RD_X;
                end else if (poll_last) begin
                    set_err = 1'b1;
                    state_d = S_STOP1;
                end else begin
                    poll_d  = poll_q + 1'b1;
                    state_d = S_POLL_RD;
                end
            end
            S_RD_X: begin
                m_read  = 1'b1;
                m_addr  = {OP_RX, body_q};
                lat_d   = '0;
                state_d = S_WT_X;
            end
            S_WT_X: begin
                if (!lat_last) begin
                    lat_d = lat_q + 1'b1;
                end else begin
                    cap_x   = 1'b1;
                    state_d = S_RD_Y;
                end
            end
            S_RD_Y: begin
                m_read  = 1'b1;
                m_addr  = {OP_RY, body_q};
                lat_d   = '0;
                state_d = S_WT_Y;
            end
            S_WT_Y: begin
                if (!lat_last) begin
                    lat_d = lat_q + 1'b1;
                end else begin
                    cap_y = 1'b1;
                    if (last_body) begin
                        state_d = S_ACK1;
                    end else begin
                        body_d  = body_q + 1'b1;
                        state_d = S_RD_X;
                    end
                end
            end
            S_ACK1: begin
                m_write     = 1'b1;
                m_addr      = {OP_READ, BW'(0)};
                m_writedata = DATA_WIDTH'(1);
                state_d     = S_ACK2;
            end
            S_ACK2: begin
                m_write = 1'b1;
                m_addr  = {OP_GO, BW'(0)};
                state_d = S_ACK3;
            end
            S_ACK3: begin
                m_write = 1'b1;
                m_addr  = {OP_READ, BW'(0)};
                state_d = S_FIN;
            end
            S_FIN: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            S_STOP1: begin
                m_write = 1'b1;
                m_addr  = {OP_GO, BW'(0)};
                state_d = S_STOP2;
            end
            S_STOP2: begin
                m_write = 1'b1;
                m_addr  = {OP_READ, BW'(0)};
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Any strobe of this cycle still goes out; abort only redirects what follows.
        if (abort && !(state_q inside {S_IDLE, S_FIN, S_STOP1, S_STOP2})) begin
            state_d = S_STOP1;
            set_err = 1'b0;
            cap_x   = 1'b0;
            cap_y   = 1'b0;
        end
    end

endmodule

// File: tb/tb_nbody_host_ctrl.sv
// Directed runs with random data; the expected bus trace is built from
// the protocol description with a cycle cursor and compared transaction by transaction.
module tb_nbody_host_ctrl;

    localparam int BAW = 9;
    localparam int DW  = 64;
    localparam int LIM = 8;

    logic           clk = 0;
    logic           rst, start, abort;
    logic [BAW-1:0] n_bodies;
    logic [DW-1:0]  gap;
    logic           busy, done_o, error;
    logic           src_rd_en;
    logic [BAW-1:0] src_rd_body;
    logic [2:0]     src_rd_field;
    logic [DW-1:0]  src_rd_data;
    logic           res_valid;
    logic [BAW-1:0] res_body;
    logic [DW-1:0]  res_x, res_y;
    logic           m_chipselect, m_write, m_read;
    logic [15:0]    m_addr;
    logic [DW-1:0]  m_writedata, m_readdata;

    nbody_host_ctrl #(.POLL_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .n_bodies(n_bodies), .gap(gap), .busy(busy),
        .done_o(done_o), .error(error),
        .src_rd_en(src_rd_en), .src_rd_body(src_rd_body),
        .src_rd_field(src_rd_field), .src_rd_data(src_rd_data),
        .res_valid(res_valid), .res_body(res_body),
        .res_x(res_x), .res_y(res_y),
        .m_chipselect(m_chipselect), .m_write(m_write),
        .m_read(m_read), .m_addr(m_addr),
        .m_writedata(m_writedata), .m_readdata(m_readdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] t;
        logic        wr;
        logic [15:0] addr;
        logic [63:0] data;
    } bus_t;

    typedef struct packed {
        logic [15:0] t;
        logic [8:0]  b;
        logic [63:0] x;
        logic [63:0] y;
    } res_t;

    int passed = 0;
    int total  = 0;
    int cyc = 0;
    int sc  = 0;
    int src_cnt, proto_bad, busy_done_bad;
    int poll_idx, zeros_cfg;
    bus_t blog[$], eq[$];
    res_t rlog[$], er[$];
    int   dlog[$];
    int   mt, exp_done, exp_src, exp_err;
    logic [63:0] src_mem[0:79];
    logic [63:0] rx[0:15], ry[0:15];

    always @(posedge clk) cyc <= cyc + 1;

    // Source memory: one-cycle read latency
    always @(posedge clk)
        if (src_rd_en)
            src_rd_data <= src_mem[int'(src_rd_body) * 5 + int'(src_rd_field)];

    // Accelerator slave: DONE follows zeros_cfg, positions from rx/ry
    always @(posedge clk) begin
        logic [63:0] v;
        if (m_read) begin
            v = {$urandom(), $urandom()};
            case (m_addr[15:9])
                7'h40: begin
                    v[0] = (poll_idx >= zeros_cfg);
                    poll_idx = poll_idx + 1;
                end
                7'h41: v = rx[m_addr[3:0]];
                7'h42: v = ry[m_addr[3:0]];
                default: ;
            endcase
            m_readdata <= v;
        end
    end

    // Trace recorder
    always @(negedge clk) begin
        bus_t e;
        res_t r;
        if (m_chipselect && (m_write ^ m_read)) begin
            e.t    = 16'(cyc - sc);
            e.wr   = m_write;
            e.addr = m_addr;
            e.data = m_write ? m_writedata : 64'h0;
            blog.push_back(e);
        end
        if (m_chipselect !== (m_write | m_read) || (m_write && m_read))
            proto_bad++;
        if (src_rd_en) src_cnt++;
        if (res_valid) begin
            r.t = 16'(cyc - sc);
            r.b = res_body;
            r.x = res_x;
            r.y = res_y;
            rlog.push_back(r);
        end
        if (done_o) begin
            dlog.push_back(cyc - sc);
            if (busy) busy_done_bad++;
        end
    end

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic mpush(bit wr, logic [6:0] op, int b, logic [63:0] d);
        bus_t e;
        e.t    = 16'(mt);
        e.wr   = wr;
        e.addr = {op, 9'(b)};
        e.data = d;
        eq.push_back(e);
        mt += wr ? 1 : 2;
    endtask

    // Expected trace: writes take 1 cycle, reads 2 (READ_LATENCY=1),
    // each preload write is preceded by one source-read cycle.
    task automatic model(int n, logic [63:0] g, int zeros, int abort_k);
        res_t r;
        int ty;
        eq.delete();
        er.delete();
        exp_done = -1;
        exp_src  = 0;
        exp_err  = 0;
        mt = 0;
        mpush(1, 7'h02, 0, 64'(n));
        mpush(1, 7'h08, 0, g);
        for (int k = 0; k < 5 * n; k++) begin
            exp_src++;
            mt++;
            mpush(1, 7'(3 + k % 5), k / 5, src_mem[k]);
            if (k == abort_k) begin
                mpush(1, 7'h00, 0, 0);
                mpush(1, 7'h01, 0, 0);
                return;
            end
        end
        mpush(1, 7'h00, 0, 1);
        for (int i = 0; i <= zeros && i < LIM; i++)
            mpush(0, 7'h40, 0, 0);
        if (zeros >= LIM) begin
            exp_err = 1;
            mpush(1, 7'h00, 0, 0);
            mpush(1, 7'h01, 0, 0);
            return;
        end
        for (int b = 0; b < n; b++) begin
            mpush(0, 7'h41, b, 0);
            ty = mt;
            mpush(0, 7'h42, b, 0);
            r.t = 16'(ty + 2);
            r.b = 9'(b);
            r.x = rx[b];
            r.y = ry[b];
            er.push_back(r);
        end
        mpush(1, 7'h01, 0, 1);
        mpush(1, 7'h00, 0, 0);
        mpush(1, 7'h01, 0, 0);
        exp_done = mt;
    endtask

    task automatic check_run(string tag);
        int nb, nr;
        chk({tag, ".nbus"}, blog.size(), eq.size());
        nb = (blog.size() < eq.size()) ? blog.size() : eq.size();
        for (int i = 0; i < nb; i++)
            chk($sformatf("%s.bus%0d", tag, i), blog[i], eq[i]);
        chk({tag, ".nres"}, rlog.size(), er.size());
        nr = (rlog.size() < er.size()) ? rlog.size() : er.size();
        for (int i = 0; i < nr; i++) begin
            chk($sformatf("%s.res%0d.tb", tag, i),
                {rlog[i].t, rlog[i].b}, {er[i].t, er[i].b});
            chk($sformatf("%s.res%0d.x", tag, i), rlog[i].x, er[i].x);
            chk($sformatf("%s.res%0d.y", tag, i), rlog[i].y, er[i].y);
        end
        chk({tag, ".ndone"}, dlog.size(), (exp_done >= 0) ? 1 : 0);
        if (dlog.size() == 1 && exp_done >= 0)
            chk({tag, ".tdone"}, dlog[0], exp_done);
        chk({tag, ".busy_at_done"}, busy_done_bad, 0);
        chk({tag, ".src_reads"}, src_cnt, exp_src);
        chk({tag, ".proto"}, proto_bad, 0);
        chk({tag, ".error"}, error, exp_err);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, ".ctl"},
            {busy, done_o, error, src_rd_en, res_valid,
             m_chipselect, m_write, m_read}, 0);
        chk({tag, ".bus"},
            {m_addr, m_writedata, res_body, src_rd_body, src_rd_field}, 0);
        chk({tag, ".res"}, {res_x, res_y}, 0);
    endtask

    task automatic launch(int n, logic [63:0] g, int zeros, int abort_k);
        for (int i = 0; i < 80; i++) src_mem[i] = {$urandom(), $urandom()};
        for (int i = 0; i < 16; i++) begin
            rx[i] = {$urandom(), $urandom()};
            ry[i] = {$urandom(), $urandom()};
        end
        model(n, g, zeros, abort_k);
        blog.delete();
        rlog.delete();
        dlog.delete();
        src_cnt = 0;
        proto_bad = 0;
        busy_done_bad = 0;
        poll_idx = 0;
        zeros_cfg = zeros;
        @(negedge clk);
        n_bodies = 9'(n);
        gap = g;
        start = 1;
        sc = cyc + 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic run(int n, logic [63:0] g, int zeros, int abort_k, string tag);
        int c;
        launch(n, g, zeros, abort_k);
        chk({tag, ".busy_t0"}, busy, 1);
        if (abort_k >= 0) begin
            while (cyc < sc + 3 + 2 * abort_k) @(negedge clk);
            abort = 1;
            @(negedge clk);
            abort = 0;
        end
        c = 0;
        while (busy === 1'b1 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        chk({tag, ".finish_in_time"}, c < 3000, 1);
        repeat (3) @(negedge clk);
        check_run(tag);
    endtask

    initial begin
        rst = 1;
        start = 0;
        abort = 0;
        n_bodies = 0;
        gap = 0;
        src_rd_data = 0;
        m_readdata = 0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 0;

        run(2, 64'd5, 0, -1, "basic");
        run(3, {$urandom(), $urandom()}, 4, -1, "poll5");
        run(1, {$urandom(), $urandom()}, 1000, -1, "timeout");
        run(2, {$urandom(), $urandom()}, 0, 7, "abort");
        run(2, {$urandom(), $urandom()}, 1, -1, "rerun");
        run(0, {$urandom(), $urandom()}, 0, -1, "n0");

        // Reset while draining body 1 (after body 0 result has landed)
        launch(2, {$urandom(), $urandom()}, 0, -1);
        while (cyc < sc + 30) @(negedge clk);
        chk("pre_rst.busy", busy, 1);
        chk("pre_rst.rx_loaded", res_x, rx[0]);
        rst = 1;
        @(negedge clk);
        chk_zero("mid_rst");
        rst = 0;
        repeat (2) @(negedge clk);

        run(2, {$urandom(), $urandom()}, 2, -1, "after_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/nbody_host_ctrl.md
# nbody_host_ctrl

Hardware bus initiator for the n-body accelerator's 16-bit register-map slave interface. It replaces the software driver loop. On `start` it:
- configures the body count and gap,
- streams initial body state from a local source memory into the accelerator,
- raises GO and polls DONE,
- reads back every body's X/Y position, then performs the READ/GO handshake to return the accelerator to idle.

It sits between a preload buffer/result consumer and the accelerator's bus-facing port.

## Interface
- BODIES, 512, maximum body count; BODY_ADDR_WIDTH = $clog2(BODIES)
- DATA_WIDTH, 64, bus data width
- ADDR_WIDTH, 16, bus address width; opcode field = ADDR_WIDTH-BODY_ADDR_WIDTH (7) MSBs
- READ_LATENCY, 1, cycles from m_read to valid m_readdata
- POLL_LIMIT, 2**20, DONE polls before timeout
- clk  in  1  clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a run; sampled only in IDLE
- abort  in  1  cancel run; sampled in any non-IDLE state
- n_bodies  in  BODY_ADDR_WIDTH  body count, latched on start
- gap  in  DATA_WIDTH  steps per run, latched on start
- busy  out  1  high from cycle after start until return to IDLE
- done_o  out  1  one-cycle pulse on successful completion
- error  out  1  sticky poll timeout flag; cleared on next start
- src_rd_en  out  1  source memory read strobe
- src_rd_body  out  BODY_ADDR_WIDTH  source body index
- src_rd_field  out  3  0=X, 1=Y, 2=M, 3=VX, 4=VY
- src_rd_data  in  DATA_WIDTH  valid exactly 1 cycle after src_rd_en
- res_valid  out  1  result pulse
- res_body  out  BODY_ADDR_WIDTH  body index of result
- res_x, res_y  out  DATA_WIDTH  read-back positions
- m_chipselect, m_write, m_read  out  1  bus strobes; chipselect high with either strobe, each strobe 1 cycle
- m_addr  out  ADDR_WIDTH  {opcode, body}
- m_writedata  out  DATA_WIDTH  write data
- m_readdata  in  DATA_WIDTH  read data

## Operation
Opcodes:
- GO 0000000, READ 0000001, N_BODIES 0000010, GAP 0001000
- WRITE_X/Y/M/VX/VY 0000011..0000111
- DONE 1000000, READ_X 1000001, READ_Y 1000010
- Body field is 0 for non-body registers.

States, in order:
- IDLE: on start, latch n_bodies/gap, clear error, go to CFG.
- CFG: write N_BODIES (data = n_bodies zero-extended), then write GAP (data = gap). One cycle each.
- LOAD: for body b=0..n-1 and field f=0..4, alternate two cycles:
  - RD: src_rd_en, src_rd_body=b, src_rd_field=f.
  - WR: m_write, opcode WRITE_f, body b, data=src_rd_data.
  - Field index increments first; b wraps to the next body after VY.
  - n_bodies=0 skips LOAD.
- GO_SET: write GO, data 1.
- POLL: read DONE, wait READ_LATENCY cycles, test m_readdata[0].
  - 1 → DRAIN.
  - 0 → increment poll counter and re-issue. Reaching POLL_LIMIT sets error and goes to STOP.
- DRAIN: per body, read READ_X, then READ_Y, each followed by READ_LATENCY wait cycles. After the Y data is captured, pulse res_valid with res_body=b and both values for one cycle. n_bodies=0 skips DRAIN.
- ACK: write READ data 1, write GO data 0, write READ data 0.
- FIN: pulse done_o, go to IDLE.
- STOP (abort or timeout): write GO data 0, write READ data 0, go to IDLE. No done_o.

Rules:
- abort has priority over all transitions, except while a bus write is issuing. That write completes, then STOP is entered.
- abort in IDLE is ignored.
- start while busy is ignored.
- start and abort in the same IDLE cycle: start wins.
- rst mid-run: all outputs return to reset values next cycle; no bus cleanup transaction is issued.
- Reset values: all outputs 0, counters 0, state IDLE.

## Timing
- busy rises the cycle after start is sampled. First bus write (N_BODIES) is in that same cycle.
- CFG = 2 cycles. LOAD = 10·n cycles. GO_SET = 1 cycle.
- Each poll = 1 + READ_LATENCY cycles.
- DRAIN = 2·(1+READ_LATENCY)·n cycles. res_valid is asserted in the cycle after the READ_Y data is captured.
- ACK = 3 cycles. done_o is in the cycle after the last ACK write. busy falls with done_o.
- No bus stalls: the slave accepts every transaction in one cycle.

## Test plan
- n=2, gap=5, DONE=1 on the first poll → writes, in order: N_BODIES=2, GAP=5, ten WRITE_* with source data, GO=1. Then DONE read, then READ_X/READ_Y for bodies 0 and 1. Two res_valid pulses with the model's values. Then READ=1, GO=0, READ=0, done_o.
- DONE returns 0 four times, then 1 → exactly 5 DONE reads, 2 cycles apart (READ_LATENCY=1), then DRAIN.
- POLL_LIMIT=8, DONE stuck at 0 → 8 polls, error=1, GO=0 and READ=0 writes, no done_o, busy=0.
- n=0 → N_BODIES=0, GAP, GO=1, DONE poll, ACK sequence. No src_rd_en, no res_valid.
- abort during LOAD body 1 field 2 → pending write completes, then GO=0, READ=0, IDLE. A new start reloads from body 0 and error=0.
- rst asserted mid-DRAIN → next cycle all outputs 0, state IDLE. The following start runs a full sequence correctly.
